// File: rtl/frame_sequencer_pkg.sv
// Shared types and constants for the per-frame obstacle pipeline scheduler.
package frame_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_STREAM = 2'd2,
        S_COMMIT = 2'd3
    } seq_state_t;

    localparam int BTN_LEFT  = 3;
    localparam int BTN_RIGHT = 2;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_UP    = 0;

endpackage

// File: rtl/frame_sequencer_camera_stepper.sv
// One-axis camera step: widen by one bit, add or subtract the step, clamp, truncate.
module camera_stepper #(
    parameter int WORLD_BITS = 18,
    parameter int STEP       = 5,
    parameter int MIN_V      = 0,
    parameter int MAX_V      = 4095
) (
    input  logic signed [WORLD_BITS-1:0] cur_i,
    input  logic                         step_en_i,
    input  logic                         step_neg_i,
    output logic signed [WORLD_BITS-1:0] next_o
);

    localparam int W1 = WORLD_BITS + 1;
    localparam logic signed [W1-1:0] STEP_W = W1'(STEP);
    localparam logic signed [W1-1:0] MIN_W  = W1'(MIN_V);
    localparam logic signed [W1-1:0] MAX_W  = W1'(MAX_V);

    function automatic logic signed [W1-1:0] clamp(input logic signed [W1-1:0] v);
        if (v < MIN_W) begin
            return MIN_W;
        end else if (v > MAX_W) begin
            return MAX_W;
        end else begin
            return v;
        end
    endfunction

    logic signed [W1-1:0] wide;
    logic signed [W1-1:0] sum;
    logic signed [W1-1:0] clamped;

    always_comb begin
        wide    = {cur_i[WORLD_BITS-1], cur_i};
        sum     = step_neg_i ? (wide - STEP_W) : (wide + STEP_W);
        clamped = clamp(sum);
        next_o  = step_en_i ? clamped[WORLD_BITS-1:0] : cur_i;
    end

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler: camera step, settle, env stream start, wait for the collector,
// then commit the camera to render so obstacle list and render camera share a frame.
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int WORLD_BITS     = 18,
    parameter int CAMERA_STEP    = 5,
    parameter int INIT_CAMERA_X  = 640,
    parameter int INIT_CAMERA_Y  = 360,
    parameter int CAM_MIN_X      = -4096,
    parameter int CAM_MAX_X      = 65535,
    parameter int CAM_MIN_Y      = 0,
    parameter int CAM_MAX_Y      = 4095,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         new_frame_in,
    input  logic [3:0]                   btn_in,
    input  logic                         collect_done_in,
    output logic signed [WORLD_BITS-1:0] camera_x_out,
    output logic signed [WORLD_BITS-1:0] camera_y_out,
    output logic signed [WORLD_BITS-1:0] render_camera_x_out,
    output logic signed [WORLD_BITS-1:0] render_camera_y_out,
    output logic                         env_start_out,
    output logic                         commit_out,
    output logic                         busy_out,
    output logic                         overrun_out,
    output logic [7:0]                   timeout_count_out
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic signed [WORLD_BITS-1:0] INIT_X = WORLD_BITS'(INIT_CAMERA_X);
    localparam logic signed [WORLD_BITS-1:0] INIT_Y = WORLD_BITS'(INIT_CAMERA_Y);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    seq_state_t                   state_q, state_d;
    logic [SET_W-1:0]             settle_q, settle_d;
    logic [TO_W-1:0]              to_q, to_d;
    logic signed [WORLD_BITS-1:0] cam_x_q, cam_x_d, cam_y_q, cam_y_d;
    logic signed [WORLD_BITS-1:0] rcam_x_q, rcam_x_d, rcam_y_q, rcam_y_d;
    logic                         env_start_q, env_start_d;
    logic                         overrun_q, overrun_d;
    logic [7:0]                   tocnt_q, tocnt_d;
    logic                         cam_load, commit;
    logic                         x_en, y_en;
    logic signed [WORLD_BITS-1:0] step_x, step_y;

    // Only one axis moves per frame; x buttons outrank y buttons.
    assign x_en = btn_in[BTN_LEFT] | btn_in[BTN_RIGHT];
    assign y_en = ~x_en & (btn_in[BTN_DOWN] | btn_in[BTN_UP]);

    camera_stepper #(
        .WORLD_BITS(WORLD_BITS), .STEP(CAMERA_STEP), .MIN_V(CAM_MIN_X), .MAX_V(CAM_MAX_X)
    ) u_step_x (
        .cur_i(cam_x_q), .step_en_i(x_en), .step_neg_i(btn_in[BTN_LEFT]), .next_o(step_x)
    );

    camera_stepper #(
        .WORLD_BITS(WORLD_BITS), .STEP(CAMERA_STEP), .MIN_V(CAM_MIN_Y), .MAX_V(CAM_MAX_Y)
    ) u_step_y (
        .cur_i(cam_y_q), .step_en_i(y_en), .step_neg_i(btn_in[BTN_DOWN]), .next_o(step_y)
    );

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        to_d        = to_q;
        tocnt_d     = tocnt_q;
        env_start_d = 1'b0;
        cam_load    = 1'b0;
        commit      = 1'b0;
        overrun_d   = overrun_q | (new_frame_in & (state_q != S_IDLE));
        case (state_q)
            S_IDLE: begin
                if (new_frame_in) begin
                    cam_load = 1'b1;
                    settle_d = SET_W'(SETTLE_CYCLES - 1);
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    env_start_d = 1'b1;
                    to_d        = '0;
                    state_d     = S_STREAM;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            S_STREAM: begin
                if (collect_done_in) begin
                    state_d = S_COMMIT;
                end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    tocnt_d = sat_inc8(tocnt_q);
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_COMMIT: begin
                commit  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        cam_x_d  = cam_load ? step_x : cam_x_q;
        cam_y_d  = cam_load ? step_y : cam_y_q;
        rcam_x_d = commit ? cam_x_q : rcam_x_q;
        rcam_y_d = commit ? cam_y_q : rcam_y_q;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            settle_q    <= '0;
            to_q        <= '0;
            cam_x_q     <= INIT_X;
            cam_y_q     <= INIT_Y;
            rcam_x_q    <= INIT_X;
            rcam_y_q    <= INIT_Y;
            env_start_q <= 1'b0;
            overrun_q   <= 1'b0;
            tocnt_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            to_q        <= to_d;
            cam_x_q     <= cam_x_d;
            cam_y_q     <= cam_y_d;
            rcam_x_q    <= rcam_x_d;
            rcam_y_q    <= rcam_y_d;
            env_start_q <= env_start_d;
            overrun_q   <= overrun_d;
            tocnt_q     <= tocnt_d;
        end
    end

    assign camera_x_out        = cam_x_q;
    assign camera_y_out        = cam_y_q;
    assign render_camera_x_out = rcam_x_q;
    assign render_camera_y_out = rcam_y_q;
    assign env_start_out       = env_start_q;
    assign commit_out          = (state_q == S_COMMIT);
    assign busy_out            = (state_q != S_IDLE);
    assign overrun_out         = overrun_q;
    assign timeout_count_out   = tocnt_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer; a second instance starts with camera y = 3 for the y clamp.
module tb_frame_sequencer;

    localparam int WB = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic new_frame = 1'b0;
    logic done = 1'b0;
    logic [3:0] btn = 4'd0;

    logic signed [WB-1:0] cx, cy, rx, ry, cx2, cy2, rx2, ry2;
    logic env_start, commit, busy, overrun, env2, commit2, busy2, ov2;
    logic [7:0] tocnt, tocnt2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    frame_sequencer #(.TIMEOUT_CYCLES(50)) u_dut (
        .clk_in(clk), .rst_in(rst), .new_frame_in(new_frame), .btn_in(btn),
        .collect_done_in(done),
        .camera_x_out(cx), .camera_y_out(cy),
        .render_camera_x_out(rx), .render_camera_y_out(ry),
        .env_start_out(env_start), .commit_out(commit), .busy_out(busy),
        .overrun_out(overrun), .timeout_count_out(tocnt)
    );

    frame_sequencer #(.TIMEOUT_CYCLES(50), .INIT_CAMERA_Y(3)) u_dut_y (
        .clk_in(clk), .rst_in(rst), .new_frame_in(new_frame), .btn_in(btn),
        .collect_done_in(done),
        .camera_x_out(cx2), .camera_y_out(cy2),
        .render_camera_x_out(rx2), .render_camera_y_out(ry2),
        .env_start_out(env2), .commit_out(commit2), .busy_out(busy2),
        .overrun_out(ov2), .timeout_count_out(tocnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cx"}, cx, 640);
        chk({tag, "_cy"}, cy, 360);
        chk({tag, "_rx"}, rx, 640);
        chk({tag, "_ry"}, ry, 360);
        chk({tag, "_env"}, env_start, 0);
        chk({tag, "_commit"}, commit, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ovr"}, overrun, 0);
        chk({tag, "_tocnt"}, tocnt, 0);
    endtask

    // Pulses new_frame with the given buttons and returns cycles until env_start is seen.
    task automatic start_frame(input logic [3:0] b, output int lat);
        new_frame = 1'b1;
        btn = b;
        tick();
        new_frame = 1'b0;
        btn = 4'd0;
        lat = 1;
        while (env_start !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic full_frame(input string tag, input logic [3:0] b,
                              input longint ecx, input longint ecy,
                              input longint erx, input longint ery);
        int lat;
        start_frame(b, lat);
        chk({tag, "_lat"}, lat, 5);
        chk({tag, "_cx"}, cx, ecx);
        chk({tag, "_cy"}, cy, ecy);
        chk({tag, "_rx_lag"}, rx, erx);
        chk({tag, "_ry_lag"}, ry, ery);
        repeat (3) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk({tag, "_commit"}, commit, 1);
        chk({tag, "_rx_pulse"}, rx, erx);
        tick();
        chk({tag, "_commit_end"}, commit, 0);
        chk({tag, "_rx"}, rx, ecx);
        chk({tag, "_ry"}, ry, ecy);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int lat, k, cseen, hung, pulses;

        rst = 1'b1;
        tick();
        tick();
        chk_reset("rst");
        rst = 1'b0;
        tick();
        chk_reset("rst_rel");

        full_frame("f1", 4'b0000, 640, 360, 640, 360);

        full_frame("left1", 4'b1000, 635, 360, 640, 360);
        full_frame("left2", 4'b1000, 630, 360, 635, 360);
        full_frame("left3", 4'b1000, 625, 360, 630, 360);

        full_frame("all1", 4'b1111, 620, 360, 625, 360);
        full_frame("all2", 4'b1111, 615, 360, 620, 360);

        full_frame("down1", 4'b0010, 615, 355, 615, 360);
        chk("clampy1_cy", cy2, 0);
        chk("clampy1_ry", ry2, 0);
        full_frame("down2", 4'b0010, 615, 350, 615, 355);
        chk("clampy2_cy", cy2, 0);

        chk("pre_to_ovr", overrun, 0);
        chk("pre_to_cnt", tocnt, 0);

        start_frame(4'b0000, lat);
        chk("to1_lat", lat, 5);
        k = 0;
        cseen = 0;
        while (busy === 1'b1 && k < 200) begin
            tick();
            k++;
            if (commit === 1'b1) cseen++;
        end
        chk("to1_len", k, 50);
        chk("to1_cnt", tocnt, 1);
        chk("to1_rx", rx, 615);
        chk("to1_ry", ry, 350);

        hung = 0;
        for (int i = 1; i < 300; i++) begin
            start_frame(4'b0000, lat);
            k = 0;
            while (busy === 1'b1 && k < 200) begin
                tick();
                k++;
                if (commit === 1'b1) cseen++;
            end
            if (k >= 200) hung++;
            if (i == 199) chk("to200_cnt", tocnt, 200);
        end
        chk("to_hung", hung, 0);
        chk("to_no_commit", cseen, 0);
        chk("to_sat", tocnt, 255);
        chk("to_rx", rx, 615);

        start_frame(4'b1000, lat);
        chk("ovr_cx0", cx, 610);
        tick();
        new_frame = 1'b1;
        btn = 4'b1000;
        tick();
        new_frame = 1'b0;
        btn = 4'd0;
        chk("ovr_set", overrun, 1);
        chk("ovr_cx", cx, 610);
        chk("ovr_busy", busy, 1);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("ovr_commit", commit, 1);
        tick();
        chk("ovr_rx", rx, 610);
        chk("ovr_sticky", overrun, 1);
        chk("ovr_cx_after", cx, 610);

        new_frame = 1'b1;
        btn = 4'b1000;
        tick();
        new_frame = 1'b0;
        btn = 4'd0;
        chk("rs_settle_cx_pre", cx, 605);
        tick();
        rst = 1'b1;
        #1;
        chk_reset("rs_settle");
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (env_start === 1'b1 || commit === 1'b1) pulses++;
        end
        chk("rs_settle_quiet", pulses, 0);
        chk("rs_settle_idle", busy, 0);

        start_frame(4'b0000, lat);
        chk("same_lat", lat, 5);
        tick();
        new_frame = 1'b1;
        done = 1'b1;
        tick();
        new_frame = 1'b0;
        done = 1'b0;
        chk("same_commit", commit, 1);
        chk("same_ovr", overrun, 1);
        chk("same_cx", cx, 640);
        tick();
        chk("same_commit_end", commit, 0);
        chk("same_idle", busy, 0);

        start_frame(4'b0100, lat);
        chk("rs_stream_cx_pre", cx, 645);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk_reset("rs_stream");
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (env_start === 1'b1 || commit === 1'b1) pulses++;
        end
        chk("rs_stream_quiet", pulses, 0);

        full_frame("post", 4'b0100, 645, 360, 640, 360);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Per-frame scheduler for the obstacle pipeline: manage_environment → get_obstacles_on_screen → render.
- On each new_frame it:
  - applies one button-driven camera step, clamped to world limits;
  - waits for the pixel_to_world bound instances to settle on the new camera;
  - pulses the environment stream start;
  - waits for the on-screen collector to finish;
  - commits the camera to render, so the obstacle list and render camera always belong to the same frame.
- Replaces the ad-hoc camera register and the direct new_frame→start_in wiring in top_level.

Parameters:
- WORLD_BITS, 18, width of signed world coordinates.
- CAMERA_STEP, 5, world units moved per frame per button.
- INIT_CAMERA_X, 640, camera x after reset.
- INIT_CAMERA_Y, 360, camera y after reset.
- CAM_MIN_X, -4096, lower x clamp (inclusive).
- CAM_MAX_X, 65535, upper x clamp (inclusive).
- CAM_MIN_Y, 0, lower y clamp (inclusive).
- CAM_MAX_Y, 4095, upper y clamp (inclusive).
- SETTLE_CYCLES, 4, cycles between camera update and env start (≥1; covers pixel_to_world latency).
- TIMEOUT_CYCLES, 200000, maximum cycles in STREAM before abort.

Ports:
- clk_in  input  1  pixel clock.
- rst_in  input  1  asynchronous, active-high reset.
- new_frame_in  input  1  one-cycle new-frame pulse from video_sig_gen.
- btn_in  input  4  camera buttons: [3] −x, [2] +x, [1] −y, [0] +y.
- collect_done_in  input  1  done pulse from get_obstacles_on_screen.
- camera_x_out  output  WORLD_BITS  signed working camera x (feeds pixel_to_world).
- camera_y_out  output  WORLD_BITS  signed working camera y.
- render_camera_x_out  output  WORLD_BITS  signed committed camera x (feeds render).
- render_camera_y_out  output  WORLD_BITS  signed committed camera y.
- env_start_out  output  1  one-cycle start pulse to manage_environment.
- commit_out  output  1  one-cycle pulse: obstacle list and render camera updated.
- busy_out  output  1  high in any state other than IDLE.
- overrun_out  output  1  sticky: a new_frame arrived while busy.
- timeout_count_out  output  8  saturating count of aborted frames.

Behaviour:
- Reset (asynchronous, immediate, any state):
  - state=IDLE;
  - camera and render camera = INIT values;
  - env_start_out=0, commit_out=0, overrun_out=0, timeout_count_out=0;
  - counters cleared.
  - Reset mid-STREAM: no commit; the next new_frame starts cleanly.
- States: IDLE, SETTLE, STREAM, COMMIT. busy_out = (state != IDLE).
- IDLE, new_frame_in=1:
  - Camera update registered on that edge. At most one axis moves per frame. Priority btn3 > btn2 > btn1 > btn0.
  - Compute in WORLD_BITS+1 signed, clamp to [CAM_MIN, CAM_MAX], truncate.
  - Settle counter loads SETTLE_CYCLES−1; next state SETTLE.
- SETTLE:
  - Decrement each cycle.
  - In the cycle the counter is 0: env_start_out=1 for exactly that cycle; next state STREAM; timeout counter loads 0.
  - Latency: new_frame edge to env_start_out high = SETTLE_CYCLES+1 cycles.
- STREAM, collect_done_in=1: next state COMMIT.
- STREAM timeout:
  - If the timeout counter reaches TIMEOUT_CYCLES−1 with no done, go to IDLE.
  - timeout_count_out increments and saturates at 255.
  - No commit; render camera unchanged.
- COMMIT (one cycle):
  - commit_out=1;
  - render_camera ← camera, visible the cycle after the pulse;
  - next state IDLE.
- collect_done_in in IDLE, SETTLE or COMMIT: ignored.
- new_frame_in while busy: frame skipped (no camera step); overrun_out ← 1.
- new_frame_in and collect_done_in in the same STREAM cycle: done wins (→ COMMIT) and overrun_out is set.
- new_frame_in in the COMMIT cycle: counted as overrun, not serviced. IDLE is always entered for at least one cycle.
- Camera outputs are stable from the SETTLE entry until the next IDLE new_frame.

Decomposition:
- Package frame_seq_pkg holds:
  - state enum seq_state_t;
  - button index constants BTN_LEFT=3, BTN_RIGHT=2, BTN_DOWN=1, BTN_UP=0.
- One sub-module, camera_stepper: combinational step, widen, clamp for one axis (instantiated for x and y).

Test Plan:
- Reset, no buttons, new_frame, then collect_done 10 cycles after env_start → env_start_out high exactly 5 cycles after new_frame; commit_out one cycle; render camera = (640,360).
- btn=4'b1000, 3 full frames → camera_x 640→635→630→625; render_camera_x lags each value until its commit.
- btn=4'b1111 → only x decreases by 5 per frame. CAM_MIN_Y=0 with camera_y=3 and btn=4'b0010 → camera_y clamps to 0, never negative.
- Withhold collect_done for TIMEOUT_CYCLES (set 50 in bench) → return to IDLE, timeout_count_out=1, no commit_out; 300 forced timeouts → count saturates at 255.
- new_frame during STREAM, then done → overrun_out=1 and stays 1; camera unchanged by the skipped frame. Same-cycle new_frame + done → commit occurs, overrun_out=1.
- Assert rst_in mid-SETTLE and mid-STREAM → all outputs return to reset values asynchronously; no env_start_out or commit_out pulse afterwards until the next new_frame.
